// File: rtl/peri_timer_array.sv
// Memory-mapped array of NUM_CH prescaled interval timers with a shared IRQ_STAT word.
// Each channel counts TL up on prescaler ticks and reloads from TH on overflow, raising STAT.
module peri_timer_array #(
    parameter int unsigned NUM_CH    = 2,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int unsigned CH_STRIDE = 16,
    parameter int unsigned PRE_W     = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iRd,
    input  logic              iWr,
    input  logic [31:0]       iAddr,
    input  logic [31:0]       iWrData,
    output logic [31:0]       oRdData,
    output logic              oHit,
    output logic [NUM_CH-1:0] oIrqVec,
    output logic              oIrq
);

    localparam logic [31:0] ChSpan     = 32'(NUM_CH * CH_STRIDE);
    localparam logic [31:0] StrideMask = 32'(CH_STRIDE - 1);
    localparam int unsigned StrideSh   = $clog2(CH_STRIDE);

    logic [31:0] off, blk, loc;
    logic        in_ch, is_irq, in_reg;

    // Offset arithmetic wraps for addresses below BASE_ADDR, so the range test rejects them.
    assign off    = (iAddr & ~32'h3) - BASE_ADDR;
    assign blk    = off >> StrideSh;
    assign loc    = off & StrideMask;
    assign in_ch  = off < ChSpan;
    assign is_irq = off == ChSpan;
    assign in_reg = in_ch && (loc < 32'd16);
    assign oHit   = in_ch || is_irq;

    logic [31:0]      th_q   [NUM_CH];
    logic [31:0]      th_d   [NUM_CH];
    logic [31:0]      tl_q   [NUM_CH];
    logic [31:0]      tl_d   [NUM_CH];
    logic [PRE_W-1:0] pre_q  [NUM_CH];
    logic [PRE_W-1:0] pre_d  [NUM_CH];
    logic [PRE_W-1:0] pcnt_q [NUM_CH];
    logic [PRE_W-1:0] pcnt_d [NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, ie_q, ie_d, stat_q, stat_d;
    logic [NUM_CH-1:0] wr_ch, tick, ovf;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_ch[c] = iWr && in_reg && (blk == 32'(c));
            tick[c]  = en_q[c] && (pcnt_q[c] == pre_q[c]);
            // A bus write to TL on the same edge replaces the tick, so no reload happens.
            ovf[c]   = tick[c] && (tl_q[c] == 32'hFFFF_FFFF) && !(wr_ch[c] && loc[3:2] == 2'd1);
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            th_d[c]   = th_q[c];
            tl_d[c]   = tl_q[c];
            pre_d[c]  = pre_q[c];
            en_d[c]   = en_q[c];
            ie_d[c]   = ie_q[c];
            stat_d[c] = stat_q[c];
            pcnt_d[c] = (!en_q[c] || tick[c]) ? '0 : pcnt_q[c] + PRE_W'(1);

            if (tick[c]) begin
                tl_d[c] = (tl_q[c] == 32'hFFFF_FFFF) ? th_q[c] : tl_q[c] + 32'd1;
            end

            if (wr_ch[c]) begin
                unique case (loc[3:2])
                    2'd0: th_d[c] = iWrData;
                    2'd1: tl_d[c] = iWrData;
                    2'd2: begin
                        en_d[c] = iWrData[0];
                        ie_d[c] = iWrData[1];
                        if (iWrData[2]) begin
                            stat_d[c] = 1'b0;
                        end
                    end
                    2'd3: begin
                        pre_d[c]  = iWrData[PRE_W-1:0];
                        pcnt_d[c] = '0;
                    end
                endcase
            end

            // Overflow wins over a W1C on the same edge so an interrupt is never lost.
            if (ovf[c]) begin
                stat_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                th_q[c]   <= '0;
                tl_q[c]   <= '0;
                pre_q[c]  <= '0;
                pcnt_q[c] <= '0;
            end
            en_q   <= '0;
            ie_q   <= '0;
            stat_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                th_q[c]   <= th_d[c];
                tl_q[c]   <= tl_d[c];
                pre_q[c]  <= pre_d[c];
                pcnt_q[c] <= pcnt_d[c];
            end
            en_q   <= en_d;
            ie_q   <= ie_d;
            stat_q <= stat_d;
        end
    end

    always_comb begin
        oRdData = '0;
        if (iRd && is_irq) begin
            oRdData = 32'(stat_q);
        end else if (iRd && in_reg) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (blk == 32'(c)) begin
                    unique case (loc[3:2])
                        2'd0: oRdData = th_q[c];
                        2'd1: oRdData = tl_q[c];
                        2'd2: oRdData = {29'd0, stat_q[c], ie_q[c], en_q[c]};
                        2'd3: oRdData = 32'(pre_q[c]);
                    endcase
                end
            end
        end
    end

    assign oIrqVec = stat_q & ie_q;
    assign oIrq    = |oIrqVec;

endmodule
